// File: rtl/fifo_read_controller_if.sv
// Read-side FIFO controller bus: write-pointer input, RAM read port, valid/ready output stream.
// master = controller side, slave = surrounding logic (RAM, synchronizer, consumer).
interface fifo_read_controller_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH:0]   wr_ptr_sync;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH:0]   words_avail;
  logic                  empty;

  modport master (
    input  wr_ptr_sync,
    input  ram_rd_data,
    input  out_ready,
    output rd_ptr,
    output ram_rd_en,
    output ram_rd_addr,
    output out_data,
    output out_valid,
    output words_avail,
    output empty
  );

  modport slave (
    output wr_ptr_sync,
    output ram_rd_data,
    output out_ready,
    input  rd_ptr,
    input  ram_rd_en,
    input  ram_rd_addr,
    input  out_data,
    input  out_valid,
    input  words_avail,
    input  empty
  );
endinterface

// File: rtl/fifo_read_controller.sv
// Read-domain side of the dual-clock frame FIFO: fetches words from a synchronous-read RAM
// and presents them through a 2-entry (head + skid) valid/ready output buffer.
module fifo_read_controller #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  fifo_read_controller_if.master       bus_io
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;

  logic [ADDR_WIDTH:0]   words_avail;
  logic                  empty;
  logic                  pop;
  logic                  fill;
  logic                  fetch;
  logic [1:0]            entries;
  logic [2:0]            occupancy;

  // Fetch decision: a fetch is allowed only if the word it returns is guaranteed a free slot.
  always_comb begin
    words_avail = bus_io.wr_ptr_sync - rd_ptr_q;
    empty       = (words_avail == '0);
    unique case (state_q)
      StEmpty: entries = 2'd0;
      StOne:   entries = 2'd1;
      StTwo:   entries = 2'd2;
      default: entries = 2'd0;
    endcase
    pop       = (state_q != StEmpty) && bus_io.out_ready;
    fill      = inflight_q;
    occupancy = {1'b0, entries} + {2'b00, inflight_q};
    fetch     = !rst && !empty && (occupancy < (3'd2 + {2'b00, pop}));
  end

  // Buffer next-state: returned data lands in the first entry still free after any pop.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    skid_d     = skid_q;
    inflight_d = fetch;
    rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, fetch};
    unique case (state_q)
      StEmpty: begin
        if (fill) begin
          head_d  = bus_io.ram_rd_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (fill && pop) begin
          head_d = bus_io.ram_rd_data;
        end else if (fill) begin
          skid_d  = bus_io.ram_rd_data;
          state_d = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          head_d = skid_q;
          if (fill) begin
            skid_d = bus_io.ram_rd_data;
          end else begin
            state_d = StOne;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      skid_q     <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_comb begin
    bus_io.rd_ptr      = rd_ptr_q;
    bus_io.ram_rd_en   = fetch;
    bus_io.ram_rd_addr = rst ? '0 : rd_ptr_q[ADDR_WIDTH-1:0];
    bus_io.out_data    = head_q;
    bus_io.out_valid   = (state_q != StEmpty);
    bus_io.words_avail = words_avail;
    bus_io.empty       = empty;
  end

endmodule
